// File: rtl/aram_arbiter.sv
// Two-port (CPU/DSP) arbiter for the shared audio RAM; memory-side outputs are registered.
// ARAM_ARBITER_ROUND_ROBIN_EN selects alternating priority on collisions; default is DSP-first fixed priority.
module aram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dsp_req,
    input  logic [ADDR_W-1:0] dsp_addr,
    input  logic              dsp_we,
    input  logic [DATA_W-1:0] dsp_wdata,
    output logic              dsp_ack,
    output logic [DATA_W-1:0] dsp_rdata,
    output logic              dsp_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Handshake: req is held until ack; a request is eligible only outside its own ack cycle.
    // ack pulses for the single cycle the access sits on the memory port; a read's rvalid pulses one cycle later.
    logic cpu_elig;
    logic dsp_elig;
    logic dsp_first;
    logic grant_cpu;
    logic grant_dsp;
    logic cpu_rd_pend;
    logic dsp_rd_pend;

`ifdef ARAM_ARBITER_ROUND_ROBIN_EN
    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DSP = 1'b1
    } grant_t;

    grant_t last_grant;
    grant_t last_grant_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_CPU;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant;
        if (grant_dsp) begin
            last_grant_next = GRANT_DSP;
        end else if (grant_cpu) begin
            last_grant_next = GRANT_CPU;
        end
    end

    assign dsp_first = (last_grant == GRANT_CPU);
`else
    assign dsp_first = 1'b1;
`endif

    always_comb begin
        cpu_elig  = cpu_req & ~cpu_ack;
        dsp_elig  = dsp_req & ~dsp_ack;
        grant_dsp = dsp_elig & (dsp_first | ~cpu_elig);
        grant_cpu = cpu_elig & ~grant_dsp;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_ack     <= 1'b0;
            dsp_ack     <= 1'b0;
            cpu_rd_pend <= 1'b0;
            dsp_rd_pend <= 1'b0;
            cpu_rvalid  <= 1'b0;
            dsp_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            dsp_rdata   <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            cpu_ack     <= grant_cpu;
            dsp_ack     <= grant_dsp;
            cpu_rd_pend <= grant_cpu & ~cpu_we;
            dsp_rd_pend <= grant_dsp & ~dsp_we;
            mem_we      <= 1'b0;
            if (grant_dsp) begin
                mem_addr  <= dsp_addr;
                mem_wdata <= dsp_wdata;
                mem_we    <= dsp_we;
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_we    <= cpu_we;
            end
            // RAM data for the address issued last cycle is valid now
            cpu_rvalid <= cpu_rd_pend;
            dsp_rvalid <= dsp_rd_pend;
            if (cpu_rd_pend) begin
                cpu_rdata <= mem_rdata;
            end
            if (dsp_rd_pend) begin
                dsp_rdata <= mem_rdata;
            end
        end
    end

endmodule
